// File: rtl/psg_pkg.sv
// Shared types and default widths for the PSG voice allocator.
package psg_pkg;
  localparam int NVOICE_DEF = 5;
  localparam int KEYW_DEF   = 7;
  localparam int RELW_DEF   = 12;
  localparam int AGEW       = 8;
  localparam int VIDXW      = 3;

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_ACTIVE  = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } ctrl_state_e;

  // Saturating age step: ages hold at all-ones instead of wrapping.
  function automatic logic [AGEW-1:0] age_inc(input logic [AGEW-1:0] a);
    return (a == '1) ? a : a + AGEW'(1);
  endfunction
endpackage

// File: rtl/psg_voice_pick.sv
// Combinational voice selection: note-on priority chain and note-off key match.
module psg_voice_pick
  import psg_pkg::*;
#(
  parameter int NVOICE = NVOICE_DEF,
  parameter int KEYW   = KEYW_DEF,
  parameter int RELW   = RELW_DEF
) (
  input  voice_state_e [NVOICE-1:0]            vstate_i,
  input  logic         [NVOICE-1:0][KEYW-1:0]  vkey_i,
  input  logic         [NVOICE-1:0][AGEW-1:0]  age_i,
  input  logic         [NVOICE-1:0][RELW-1:0]  cnt_i,
  input  logic                                 req_on_i,
  input  logic         [KEYW-1:0]              req_key_i,
  output logic         [VIDXW-1:0]             idx_o,
  output logic                                 hit_o,
  output logic                                 steal_o
);
  logic             ret_f, off_f, idle_f, rel_f, act_f;
  logic [VIDXW-1:0] ret_i, off_i, idle_i, rel_i, act_i;
  logic [RELW-1:0]  rel_best;
  logic [AGEW-1:0]  act_best;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    idx_o    = '0;
    hit_o    = 1'b0;
    steal_o  = 1'b0;
    ret_f    = 1'b0;  ret_i  = '0;
    off_f    = 1'b0;  off_i  = '0;
    idle_f   = 1'b0;  idle_i = '0;
    rel_f    = 1'b0;  rel_i  = '0;  rel_best = '0;
    act_f    = 1'b0;  act_i  = '0;  act_best = '0;

    // Ascending scan with strict compares keeps the lowest index on ties.
    for (int v = 0; v < NVOICE; v++) begin
      if (!ret_f && vstate_i[v] != V_IDLE && vkey_i[v] == req_key_i) begin
        ret_f = 1'b1;  ret_i = VIDXW'(v);
      end
      if (!off_f && vstate_i[v] == V_ACTIVE && vkey_i[v] == req_key_i) begin
        off_f = 1'b1;  off_i = VIDXW'(v);
      end
      if (!idle_f && vstate_i[v] == V_IDLE) begin
        idle_f = 1'b1;  idle_i = VIDXW'(v);
      end
      if (vstate_i[v] == V_RELEASE && (!rel_f || cnt_i[v] < rel_best)) begin
        rel_f = 1'b1;  rel_i = VIDXW'(v);  rel_best = cnt_i[v];
      end
      if (vstate_i[v] == V_ACTIVE && (!act_f || age_i[v] > act_best)) begin
        act_f = 1'b1;  act_i = VIDXW'(v);  act_best = age_i[v];
      end
    end

    if (req_on_i) begin
      hit_o = 1'b1;
      if (ret_f)       idx_o = ret_i;
      else if (idle_f) idx_o = idle_i;
      else if (rel_f)  begin idx_o = rel_i; steal_o = 1'b1; end
      else             begin idx_o = act_i; steal_o = 1'b1; end
    end else if (off_f) begin
      idx_o = off_i;
      hit_o = 1'b1;
    end
  end
endmodule

// File: rtl/psg_voice_alloc.sv
// PSG voice allocator: 3-cycle request controller, per-voice state, ages and release counters.
module psg_voice_alloc
  import psg_pkg::*;
#(
  parameter int NVOICE = NVOICE_DEF,
  parameter int KEYW   = KEYW_DEF,
  parameter int RELW   = RELW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_on,
  input  logic [KEYW-1:0]        req_key,
  input  logic [RELW-1:0]        rel_time,
  output logic [NVOICE-1:0]      gate_o,
  output logic [NVOICE-1:0]      mix_sel_o,
  output logic [NVOICE*KEYW-1:0] key_o,
  output logic                   done_o,
  output logic [VIDXW-1:0]       done_voice,
  output logic                   done_hit,
  output logic                   done_steal
);
  ctrl_state_e                         fsm_q, fsm_d;
  logic                                on_q;
  logic         [KEYW-1:0]             rkey_q;
  logic         [VIDXW-1:0]            pick_idx_q, pick_idx;
  logic                                pick_hit_q, pick_hit, pick_steal_q, pick_steal;
  voice_state_e [NVOICE-1:0]           vstate_q, vstate_d;
  logic         [NVOICE-1:0][KEYW-1:0] vkey_q, vkey_d;
  logic         [NVOICE-1:0][AGEW-1:0] age_q, age_d;
  logic         [NVOICE-1:0][RELW-1:0] cnt_q, cnt_d;
  logic         [NVOICE-1:0]           gate_q, gate_d, mix_q, mix_d;
  logic                                done_q, done_hit_q, done_steal_q;
  logic         [VIDXW-1:0]            done_voice_q;

  psg_voice_pick #(.NVOICE(NVOICE), .KEYW(KEYW), .RELW(RELW)) u_pick (
    .vstate_i (vstate_q),
    .vkey_i   (vkey_q),
    .age_i    (age_q),
    .cnt_i    (cnt_q),
    .req_on_i (on_q),
    .req_key_i(rkey_q),
    .idx_o    (pick_idx),
    .hit_o    (pick_hit),
    .steal_o  (pick_steal)
  );

  always_comb begin
    fsm_d     = fsm_q;
    req_ready = (fsm_q == S_IDLE);
    unique case (fsm_q)
      S_IDLE:   if (req_valid) fsm_d = S_SCAN;
      S_SCAN:   fsm_d = S_COMMIT;
      S_COMMIT: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    vstate_d = vstate_q;
    vkey_d   = vkey_q;
    age_d    = age_q;
    cnt_d    = cnt_q;
    gate_d   = '0;
    mix_d    = '0;
    for (int v = 0; v < NVOICE; v++) begin
      if (vstate_q[v] == V_RELEASE) begin
        if (cnt_q[v] == '0) vstate_d[v] = V_IDLE;
        else                cnt_d[v]    = cnt_q[v] - RELW'(1);
      end
    end
    // Commit is applied after the expiry pass so it overrides a same-cycle expiry.
    if (fsm_q == S_COMMIT) begin
      for (int v = 0; v < NVOICE; v++) begin
        if (VIDXW'(v) == pick_idx_q) begin
          if (on_q) begin
            vstate_d[v] = V_ACTIVE;
            vkey_d[v]   = rkey_q;
            age_d[v]    = '0;
            cnt_d[v]    = '0;
          end else if (pick_hit_q) begin
            vstate_d[v] = (rel_time == '0) ? V_IDLE : V_RELEASE;
            cnt_d[v]    = rel_time;
          end
        end else if (on_q && vstate_q[v] != V_IDLE) begin
          age_d[v] = age_inc(age_q[v]);
        end
      end
    end
    for (int v = 0; v < NVOICE; v++) begin
      gate_d[v] = (vstate_d[v] == V_ACTIVE);
      mix_d[v]  = (vstate_d[v] != V_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      fsm_q        <= S_IDLE;
      on_q         <= 1'b0;
      rkey_q       <= '0;
      pick_idx_q   <= '0;
      pick_hit_q   <= 1'b0;
      pick_steal_q <= 1'b0;
      for (int v = 0; v < NVOICE; v++) vstate_q[v] <= V_IDLE;
      vkey_q       <= '0;
      age_q        <= '0;
      cnt_q        <= '0;
      gate_q       <= '0;
      mix_q        <= '0;
      done_q       <= 1'b0;
      done_voice_q <= '0;
      done_hit_q   <= 1'b0;
      done_steal_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == S_IDLE && req_valid) begin
        on_q   <= req_on;
        rkey_q <= req_key;
      end
      if (fsm_q == S_SCAN) begin
        pick_idx_q   <= pick_idx;
        pick_hit_q   <= pick_hit;
        pick_steal_q <= pick_steal;
      end
      vstate_q     <= vstate_d;
      vkey_q       <= vkey_d;
      age_q        <= age_d;
      cnt_q        <= cnt_d;
      gate_q       <= gate_d;
      mix_q        <= mix_d;
      done_q       <= (fsm_q == S_COMMIT);
      done_voice_q <= (fsm_q == S_COMMIT) ? pick_idx_q : '0;
      done_hit_q   <= (fsm_q == S_COMMIT) && pick_hit_q;
      done_steal_q <= (fsm_q == S_COMMIT) && pick_steal_q;
    end
  end

  assign gate_o     = gate_q;
  assign mix_sel_o  = mix_q;
  assign key_o      = vkey_q;
  assign done_o     = done_q;
  assign done_voice = done_voice_q;
  assign done_hit   = done_hit_q;
  assign done_steal = done_steal_q;
endmodule
